// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: state encoding,
// default instruction-memory geometry and frame constants.
package prog_loader_pkg;

  // Loader FSM encoding (3 bits).
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Defaults matching the cpu fetch port (5-bit address, 8-bit words).
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  // Largest payload that fits the instruction memory.
  localparam int MAX_LEN  = 32;

  // Starting value of the XOR checksum accumulator.
  localparam int CHK_INIT = 0;

endpackage

// File: rtl/prog_loader.sv
// Program loader: takes a framed byte stream (length, payload[, checksum])
// over valid/ready, writes the payload into instruction memory from address 0
// and releases the cpu once the frame is complete.
// Optional build macro: PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte and the CHECK state; without it DATA goes straight to DONE.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic              error_o
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_len;    // frame length N (1..32)
  logic [ADDR_W:0]   r_cnt;    // payload bytes accepted so far
  logic [ADDR_W-1:0] r_addr;   // next write address
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_accept;
  logic              w_len_bad;
  logic              w_last;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_acc;
`endif

  assign w_accept  = in_valid_i && in_ready_o;
  assign w_len_bad = (in_data_i == '0) || (in_data_i > DATA_W'(MAX_LEN));
  assign w_last    = (r_cnt == (r_len - 1'b1));

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic: frame sequencing; start_i only honoured when not busy.
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_LEN;
      S_LEN:   if (w_accept) w_next = w_len_bad ? S_ERR : S_DATA;
      S_DATA: begin
        if (w_accept && w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: if (w_accept) w_next = (in_data_i == r_acc) ? S_DONE : S_ERR;
`endif
      S_DONE:  if (start_i) w_next = S_LEN;
      S_ERR:   if (start_i) w_next = S_LEN;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode: status and ready are pure functions of the state.
  always_comb begin
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    cpu_run_o  = 1'b0;
    error_o    = 1'b0;
    case (r_state)
      S_LEN, S_DATA, S_CHECK: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_DONE:  cpu_run_o = 1'b1;
      S_ERR:   error_o   = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length/address counters and the registered write port.
  // A reset clears the strobe at the same edge, cancelling a pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept && (r_state == S_DATA);
      if (w_accept && r_state == S_LEN) begin
        r_len  <= in_data_i[ADDR_W:0];
        r_cnt  <= '0;
        r_addr <= '0;
      end
      if (w_accept && r_state == S_DATA) begin
        r_waddr <= r_addr;
        r_wdata <= in_data_i;
        r_addr  <= r_addr + 1'b1;   // wraps to 0 after 31; no write follows
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Checksum accumulator: seeded with the length byte, XORs each payload byte.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_acc <= DATA_W'(CHK_INIT);
    end else if (w_accept && r_state == S_LEN) begin
      r_acc <= in_data_i;
    end else if (w_accept && r_state == S_DATA) begin
      r_acc <= r_acc ^ in_data_i;
    end
  end
`endif

  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_waddr;
  assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader. Expected memory writes are queued when a
// payload byte is handed over and matched by a negedge monitor, including
// the one-cycle write latency. Honours PROG_LOADER_CHECKSUM_EN like the RTL.
module tb_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready_o;
  logic       mem_we_o;
  logic [4:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic       cpu_run_o;
  logic       busy_o;
  logic       error_o;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         due;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  prog_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .cpu_run_o   (cpu_run_o),
    .busy_o      (busy_o),
    .error_o     (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the queue head in the exact cycle.
  always @(negedge clk) begin
    if (mem_we_o) begin
      if (q.size() == 0) begin
        check("unexpected_write", 32'(mem_we_o), 32'd0);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("write_addr",  32'(mem_addr_o),  32'(e.addr));
        check("write_data",  32'(mem_wdata_o), 32'(e.data));
        check("write_cycle", 32'(cyc),         32'(e.due));
      end
    end else if (q.size() != 0 && q[0].due < cyc) begin
      check("write_missing", 32'(mem_we_o), 32'd1);
      void'(q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Hold one byte until accepted; payload bytes queue an expected write.
  task automatic send_byte(input logic [7:0] b, input bit payload, input logic [4:0] a);
    int  n;
    wr_t e;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      n++;
      if (n > 50) break;
    end
    if (!in_ready_o) begin
      check("accept_timeout", 32'(in_ready_o), 32'd1);
    end else if (payload) begin
      e.addr = a;
      e.data = b;
      e.due  = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] b);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(b, 1'b0, 5'd0);
`endif
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_ready"}, 32'(in_ready_o),  32'd0);
    check({tag, "_we"},    32'(mem_we_o),    32'd0);
    check({tag, "_addr"},  32'(mem_addr_o),  32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata_o), 32'd0);
    check({tag, "_run"},   32'(cpu_run_o),   32'd0);
    check({tag, "_busy"},  32'(busy_o),      32'd0);
    check({tag, "_err"},   32'(error_o),     32'd0);
  endtask

  initial begin
    logic [7:0] x;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick(3);
    check_outputs_idle("reset");
    rst_n = 1'b1;
    tick(1);

    // Frame 1: 03 | 11 22 33 | 03
    pulse_start();
    check("len_ready", 32'(in_ready_o), 32'd1);
    check("len_busy",  32'(busy_o),     32'd1);
    send_byte(8'h03, 1'b0, 5'd0);
    send_byte(8'h11, 1'b1, 5'd0);
    send_byte(8'h22, 1'b1, 5'd1);
    send_byte(8'h33, 1'b1, 5'd2);
    send_chk(8'h03);
    tick(1);
    check("f1_run",  32'(cpu_run_o), 32'd1);
    check("f1_err",  32'(error_o),   32'd0);
    check("f1_busy", 32'(busy_o),    32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Same frame with a wrong checksum: writes still happen, frame rejected.
    pulse_start();
    check("restart_run_drop", 32'(cpu_run_o), 32'd0);
    send_byte(8'h03, 1'b0, 5'd0);
    send_byte(8'h11, 1'b1, 5'd0);
    send_byte(8'h22, 1'b1, 5'd1);
    send_byte(8'h33, 1'b1, 5'd2);
    send_byte(8'h04, 1'b0, 5'd0);
    tick(1);
    check("badchk_err", 32'(error_o),   32'd1);
    check("badchk_run", 32'(cpu_run_o), 32'd0);
`endif

    // Bad lengths: 00 and 21 are both rejected without any write.
    pulse_start();
    send_byte(8'h00, 1'b0, 5'd0);
    tick(1);
    check("len00_err",   32'(error_o),    32'd1);
    check("len00_ready", 32'(in_ready_o), 32'd0);
    pulse_start();
    check("err_recover_busy", 32'(busy_o), 32'd1);
    check("err_recover_err",  32'(error_o), 32'd0);
    send_byte(8'h21, 1'b0, 5'd0);
    tick(2);
    check("len21_err", 32'(error_o),   32'd1);
    check("len21_run", 32'(cpu_run_o), 32'd0);

    // Full-depth frame: 32 bytes, addresses 0..31, checksum 20^00^..^1F = 20.
    pulse_start();
    send_byte(8'h20, 1'b0, 5'd0);
    for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b1, 5'(i));
    send_chk(8'h20);
    tick(3);
    check("full_run",  32'(cpu_run_o), 32'd1);
    check("full_q",    32'(q.size()),   32'd0);

    // Start with valid high in DONE: byte not taken that cycle, taken in LEN.
    in_valid = 1'b1;
    in_data  = 8'h04;
    start    = 1'b1;
    @(negedge clk);
    check("start_cycle_ready", 32'(in_ready_o), 32'd0);
    tick(1);
    start = 1'b0;
    send_byte(8'h04, 1'b0, 5'd0);
    // Gapped payload with a start pulse mid-DATA.
    send_byte(8'h10, 1'b1, 5'd0);
    tick(2);
    send_byte(8'h20, 1'b1, 5'd1);
    pulse_start();
    check("mid_start_busy", 32'(busy_o), 32'd1);
    tick(1);
    send_byte(8'h30, 1'b1, 5'd2);
    tick(1);
    send_byte(8'h40, 1'b1, 5'd3);
    send_chk(8'h44);
    tick(1);
    check("gap_run", 32'(cpu_run_o), 32'd1);
    check("gap_err", 32'(error_o),   32'd0);

    // Reset after the second payload byte: its write still shows, then idle.
    pulse_start();
    send_byte(8'h03, 1'b0, 5'd0);
    send_byte(8'hA1, 1'b1, 5'd0);
    send_byte(8'hA2, 1'b1, 5'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_outputs_idle("midreset");
    tick(3);
    check("midreset_q", 32'(q.size()), 32'd0);

    // Fresh frame after reset: 02 | 5A A5 | FD
    pulse_start();
    send_byte(8'h02, 1'b0, 5'd0);
    send_byte(8'h5A, 1'b1, 5'd0);
    send_byte(8'hA5, 1'b1, 5'd1);
    x = 8'h02 ^ 8'h5A ^ 8'hA5;
    send_chk(x);
    tick(3);
    check("final_run", 32'(cpu_run_o), 32'd1);
    check("final_q",   32'(q.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always ends with a summary.
  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
